// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder. One full-adder slice consumes one bit of
// each operand per cycle, LSB first. The controller uses a start/busy/done
// handshake. sum, cout and overflow are updated only when an addition
// completes, and they hold that value until the next completion.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // RUN   | one operand bit processed per edge, LSB first
  // DONE  | one-cycle done pulse; start here is accepted back-to-back

  // The counter is one bit wider than log2(WIDTH), so it cannot wrap
  // before it reaches WIDTH-1.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_s;
  logic carry_s;
  logic last_bit;
  logic accept;

  // Full-adder slice and the handshake decode.
  always_comb begin
    bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    carry_s  = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
    last_bit = (cnt_q == CW'(WIDTH - 1));
    // start is ignored while RUN and is accepted from both IDLE and DONE.
    accept   = start && (state_q != S_RUN);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, shifting, and result commit on the final bit.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sr_d   = a;
      b_sr_d   = b;
      res_sr_d = '0;
      c_d      = cin;
      cnt_d    = '0;
    end else if (state_q == S_RUN) begin
      a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
      res_sr_d = {bit_s, res_sr_q[WIDTH-1:1]};
      c_d      = carry_s;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
        sum_d  = {bit_s, res_sr_q[WIDTH-1:1]};
        cout_d = carry_s;
        // On the MSB, c_q is the carry into the MSB.
        ovf_d  = c_q ^ carry_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    sum      = sum_q;
    cout     = cout_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder with WIDTH = 16. It applies a table of directed
// vectors, several hand-written multi-cycle sequences, and randomized
// operands. Each result is checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1000;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consecutive results must be at least WIDTH+1 cycles apart.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (cyc - last_done < W + 1) begin
        errors++;
        $display("FAIL done_spacing actual=%0d required>=%0d", cyc - last_done, W + 1);
      end
      last_done = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive operands at the negedge so that start is sampled at the next edge
  // (T0). On return, time is just after T0 and start is low unless hold is set.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic hold);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Advance at least one edge, then keep advancing until done is seen or the
  // cycle budget runs out. Also counts the busy cycles seen along the way.
  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    do begin
      bc += int'(busy);
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bc;
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done(lat, bc);
      chk("latency", 32'(lat), 32'(W));
      chk("busy_cycles", 32'(bc), 32'(W));
      chk("sum", 32'(sum), 32'(vecs[i].s));
      chk("cout", 32'(cout), 32'(vecs[i].co));
      chk("overflow", 32'(overflow), 32'(vecs[i].ov));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(vecs[i].s));
    end

    // Start and operand changes during RUN are ignored
    launch(16'h1234, 16'h4321, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); a = 16'hAAAA; b = 16'hAAAA; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat, bc);
    chk("ignore_start_lat", 32'(lat), 32'd11);
    chk("ignore_start_sum", 32'(sum), 32'h5556);
    chk("ignore_start_cout", 32'(cout), 32'd0);

    // Reset during RUN aborts the operation
    launch(16'h1111, 16'h0001, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("after_rst_no_done", 32'(done), 32'd0);
    end
    launch(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    wait_done(lat, bc);
    chk("post_rst_lat", 32'(lat), 32'(W));
    chk("post_rst_sum", 32'(sum), 32'h1000);

    // start held high gives back-to-back operations
    launch(16'h0003, 16'h0004, 1'b0, 1'b1);
    wait_done(lat, bc);
    chk("b2b_first_lat", 32'(lat), 32'(W));
    chk("b2b_first_sum", 32'(sum), 32'h0007);
    a = 16'hFFFE; b = 16'h0003;
    wait_done(lat, bc);
    start = 1'b0;
    chk("b2b_spacing", 32'(lat), 32'(W + 1));
    chk("b2b_second_sum", 32'(sum), 32'h0001);
    chk("b2b_second_cout", 32'(cout), 32'd1);
    chk("b2b_second_ovf", 32'(overflow), 32'd0);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i % 5 == 0) ra = {W{1'b1}};
      if (i % 7 == 0) rb = {1'b1, {(W-1){1'b0}}};
      if ($urandom_range(0, 1) == 1) begin
        a = ra; b = rb; cin = rc; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        launch(ra, rb, rc, 1'b0);
      end
      r = ref_add(ra, rb, rc);
      wait_done(lat, bc);
      chk("rnd_lat", 32'(lat), 32'(W));
      chk("rnd_sum", 32'(sum), 32'(r[W-1:0]));
      chk("rnd_cout", 32'(cout), 32'(r[W]));
      chk("rnd_ovf", 32'(overflow), 32'(r[W+1]));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two's-complement adder/accumulator.
- Each cycle it consumes one bit of each operand, LSB first, through a single full-adder slice (sum = a ^ b ^ c; carry = majority).
- It is the first sequential datapath stage built on the combinational gate library; its per-bit sum path is fed by the _xor gate.
- It trades WIDTH cycles of latency for one adder slice, with a start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled on rising clk edges.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- cin  input  1  carry-in; captured only on an accepted start.
- busy  output  1  high while the serial addition is in progress.
- done  output  1  one-cycle pulse marking that sum/cout/overflow hold a new result.
- sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock domain, clk. Reset is asynchronous and active-low on rst_n, named as in the rest of the codebase (clk, rst_n).

Reset (rst_n = 0, asserted asynchronously at any time):
- State goes to IDLE.
- busy = 0, done = 0, sum = 0, cout = 0, overflow = 0.
- Internal shift registers, carry flop and bit counter are cleared.
- Reset release is sampled synchronously: the first operation can be accepted on the first rising edge with rst_n = 1.

State machine: IDLE, RUN, DONE.
- IDLE: busy = 0, done = 0.
  - start = 1 at edge T0: latch a, b into shift registers and cin into the carry flop; clear count; go to RUN.
- RUN: busy = 1.
  - On each edge: bit = a_sr[0] ^ b_sr[0] ^ c.
  - c <= (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0])).
  - Shift a_sr and b_sr right; shift bit into the result shift register from the MSB side; count++.
  - On the edge processing bit WIDTH-1 (edge T_WIDTH):
    - write the completed result into sum;
    - write the final carry into cout;
    - write overflow = (carry into MSB) ^ (carry out of MSB);
    - go to DONE.
- DONE: busy = 0, done = 1 for exactly one cycle.
  - start = 1 on the next edge: accepted exactly as from IDLE (back-to-back, no idle gap); go to RUN.
  - Otherwise go to IDLE.

Latency and output holding:
- Start sampled at edge T0; busy = 1 from T0 to T_WIDTH; done = 1 from T_WIDTH to T_WIDTH+1.
- Total latency is WIDTH cycles from the start edge to done.
- sum, cout and overflow change only at T_WIDTH. They hold their value through IDLE and through the next RUN until the next completion.

Boundary conditions:
- start while RUN: ignored. No re-latch, no effect on the result.
- a, b, cin changing during RUN: no effect (operands already captured).
- start held high continuously: operations run back-to-back, one result every WIDTH+1 cycles.
- Reset during RUN: the operation is aborted, no done pulse, outputs return to 0.
- Full wrap-around: 0xFFFF + 0x0001 yields sum 0, cout = 1.
- cin = 1 with a = b = all-ones: sum = all-ones, cout = 1, overflow = 0.
- Carry flop width is 1. Counter width is $clog2(WIDTH)+1; it must not wrap before count reaches WIDTH.

Test Plan (WIDTH = 16):
1. a=0x0001, b=0x0001, cin=0, start pulse → done exactly 16 edges after start edge; sum=0x0002, cout=0, overflow=0; busy high for 16 cycles; done high for 1 cycle.
2. a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
3. a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. At edge 5 of RUN change a/b to 0xAAAA and pulse start → ignored; result still 0x5556.
4. Assert rst_n=0 mid-RUN (after 8 edges) → busy/done/sum/cout/overflow immediately 0, no done pulse; release, then a=0x00FF, b=0x0F01 → sum=0x1000.
5. Hold start=1 with a=0x0003, b=0x0004, then a=0xFFFE, b=0x0003 presented during the DONE cycle → first result 0x0007; second accepted at the edge after done, giving 0x0001, cout=1, 17 cycles after the first done.
6. Randomized 200 operand/cin triples → sum, cout, overflow match a + b + cin reference model; each done spaced ≥ 17 cycles apart.
